// File: rtl/csi_crc_pkg.sv
// csi_crc_pkg: shared FSM states, CRC constants and legal NUM_BYTES list
package csi_crc_pkg;
   typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_RX, DONE} state_t;
   localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
   localparam logic [15:0] CRC_SEED = 16'hFFFF;
   localparam int NUM_BYTES_LEGAL [4] = '{1, 2, 4, 8};
   function automatic logic num_bytes_legal(input int n);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 4; i++) ok = ok | (n == NUM_BYTES_LEGAL[i]);
      return ok;
   endfunction
endpackage

// File: rtl/csi_crc16_step.sv
// csi_crc16_step: one-byte reflected CRC-16 update (crc_i, data_i -> crc_o)
module csi_crc16_step
   import csi_crc_pkg::*;
(
   input  logic [15:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [15:0] crc_o
);
   logic [15:0] c;
   always_comb begin
      c = crc_i ^ {8'h00, data_i};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
      crc_o = c;
   end
endmodule

// File: rtl/csi_crc16_engine.sv
// csi_crc16_engine: CSI-2 long-packet payload CRC-16 check
// Ports: clk_i/reset_i clock and sync reset; start_i + word_count_i open a packet;
// data_i/data_valid_i payload beats (byte 0 first); busy_o packet open;
// crc_calc_o/crc_recv_o/crc_error_o result, qualified by the crc_valid_o pulse.
module csi_crc16_engine
   import csi_crc_pkg::*;
#(
   parameter int          NUM_BYTES = 4,
   parameter logic [15:0] SEED      = CRC_SEED
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic [15:0]            word_count_i,
   input  logic [8*NUM_BYTES-1:0] data_i,
   input  logic                   data_valid_i,
   output logic                   busy_o,
   output logic [15:0]            crc_calc_o,
   output logic [15:0]            crc_recv_o,
   output logic                   crc_valid_o,
   output logic                   crc_error_o
);
   if (!num_bytes_legal(NUM_BYTES)) begin : g_bad_num_bytes
      $error("csi_crc16_engine: NUM_BYTES must be 1, 2, 4 or 8");
   end
   state_t      state;
   logic [15:0] crc, rem, eff_rem, consumed, rem_next, crc_start, crc_next;
   logic [1:0]  idx, eff_idx, nidx;
   logic [7:0]  acc, recv_lo, recv_hi;
   logic        in_pkt;
   // A start in the same cycle as a beat makes the beat belong to the new packet,
   // so the beat logic always works from these "effective" packet-start values.
   assign in_pkt    = (state == PAYLOAD) || (state == CRC_RX);
   assign eff_rem   = start_i ? word_count_i : rem;
   assign eff_idx   = start_i ? 2'd0 : idx;
   assign crc_start = start_i ? SEED : crc;
   assign consumed  = (eff_rem < 16'(NUM_BYTES)) ? eff_rem : 16'(NUM_BYTES);
   assign rem_next  = eff_rem - consumed;
   // Byte lanes below the remaining count are payload and fold into the chain;
   // later lanes pass the CRC through untouched.
   for (genvar g = 0; g < NUM_BYTES; g++) begin : g_step
      logic [15:0] c_in, c_st, c_out;
      if (g == 0) begin : g_first
         assign c_in = crc_start;
      end else begin : g_next
         assign c_in = g_step[g-1].c_out;
      end
      csi_crc16_step u_step (.crc_i(c_in), .data_i(data_i[8*g +: 8]), .crc_o(c_st));
      assign c_out = (16'(g) < eff_rem) ? c_st : c_in;
   end
   assign crc_next = g_step[NUM_BYTES-1].c_out;
   // Lanes past the payload are CRC bytes, LSB first; anything after the second is ignored.
   always_comb begin
      nidx    = eff_idx;
      recv_lo = start_i ? 8'h00 : acc;
      recv_hi = 8'h00;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (16'(i) >= eff_rem) begin
            if (nidx == 2'd0) begin
               recv_lo = data_i[8*i +: 8];
               nidx    = 2'd1;
            end else if (nidx == 2'd1) begin
               recv_hi = data_i[8*i +: 8];
               nidx    = 2'd2;
            end
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= IDLE;
         crc         <= SEED;
         rem         <= 16'h0000;
         idx         <= 2'd0;
         acc         <= 8'h00;
         busy_o      <= 1'b0;
         crc_valid_o <= 1'b0;
         crc_error_o <= 1'b0;
         crc_calc_o  <= 16'h0000;
         crc_recv_o  <= 16'h0000;
      end else begin
         crc_valid_o <= 1'b0;
         if (data_valid_i && (start_i || in_pkt)) begin
            crc    <= crc_next;
            rem    <= rem_next;
            idx    <= nidx;
            acc    <= recv_lo;
            busy_o <= 1'b1;
            if (nidx == 2'd2) begin
               state       <= DONE;
               crc_valid_o <= 1'b1;
               crc_calc_o  <= crc_next;
               crc_recv_o  <= {recv_hi, recv_lo};
               crc_error_o <= crc_next != {recv_hi, recv_lo};
            end else begin
               state <= (rem_next == 16'h0000) ? CRC_RX : PAYLOAD;
            end
         end else if (start_i) begin
            crc    <= SEED;
            rem    <= word_count_i;
            idx    <= 2'd0;
            acc    <= 8'h00;
            busy_o <= 1'b1;
            state  <= (word_count_i == 16'h0000) ? CRC_RX : PAYLOAD;
         end else if (state == DONE) begin
            state  <= IDLE;
            busy_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_csi_crc16_engine.sv
// tb_csi_crc16_engine: directed checks of csi_crc16_engine at NUM_BYTES 1, 4 and 8
module tb_csi_crc16_engine;
   logic        clk = 1'b0;
   logic        rst [3];
   logic        start [3];
   logic [15:0] wc [3];
   logic [63:0] data [3];
   logic        dv [3];
   logic        busy [3];
   logic        cv [3];
   logic        err [3];
   logic [15:0] calc [3];
   logic [15:0] recv [3];
   int          vcnt [3] = '{0, 0, 0};
   int          errors = 0;
   int          checks = 0;
   always #5 clk = ~clk;
   csi_crc16_engine #(.NUM_BYTES(1)) u_nb1 (
      .clk_i(clk), .reset_i(rst[0]), .start_i(start[0]), .word_count_i(wc[0]),
      .data_i(data[0][7:0]), .data_valid_i(dv[0]), .busy_o(busy[0]), .crc_calc_o(calc[0]),
      .crc_recv_o(recv[0]), .crc_valid_o(cv[0]), .crc_error_o(err[0]));
   csi_crc16_engine #(.NUM_BYTES(4)) u_nb4 (
      .clk_i(clk), .reset_i(rst[1]), .start_i(start[1]), .word_count_i(wc[1]),
      .data_i(data[1][31:0]), .data_valid_i(dv[1]), .busy_o(busy[1]), .crc_calc_o(calc[1]),
      .crc_recv_o(recv[1]), .crc_valid_o(cv[1]), .crc_error_o(err[1]));
   csi_crc16_engine #(.NUM_BYTES(8)) u_nb8 (
      .clk_i(clk), .reset_i(rst[2]), .start_i(start[2]), .word_count_i(wc[2]),
      .data_i(data[2]), .data_valid_i(dv[2]), .busy_o(busy[2]), .crc_calc_o(calc[2]),
      .crc_recv_o(recv[2]), .crc_valid_o(cv[2]), .crc_error_o(err[2]));
   always @(posedge clk) for (int d = 0; d < 3; d++) if (cv[d]) vcnt[d]++;
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] crc_ref(input logic [7:0] s [$], input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ s[i][b];
            c  = c >> 1;
            if (fb) c = c ^ 16'h8408;
         end
      return c;
   endfunction
   // Sends a whole packet (payload followed by CRC bytes), then checks the
   // one-cycle latency and single-cycle width of crc_valid_o.
   task automatic run_pkt(input int d, input int nb, input logic [15:0] w, input logic [7:0] s [$],
                          input logic gaps, input logic st_beat);
      int          n;
      logic [63:0] beat;
      n = 0;
      @(negedge clk);
      start[d] = 1'b1;
      wc[d]    = w;
      dv[d]    = 1'b0;
      if (!st_beat) begin
         @(negedge clk);
         start[d] = 1'b0;
      end
      while (n < s.size()) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            dv[d]   = 1'b0;
            data[d] = {$urandom, $urandom};
         end else begin
            beat = {8{8'hA5}};
            for (int k = 0; k < nb; k++) if (n < s.size()) beat[8*k +: 8] = s[n++];
            data[d] = beat;
            dv[d]   = 1'b1;
         end
         @(negedge clk);
         start[d] = 1'b0;
      end
      dv[d] = 1'b0;
      check("valid_latency", 16'(cv[d]), 16'd1);
      @(negedge clk);
      check("valid_pulse", 16'(cv[d]), 16'd0);
      check("idle_after", 16'(busy[d]), 16'd0);
   endtask
   task automatic partial(input int d, input int nb, input logic [15:0] w, input logic [7:0] s [$],
                          input int beats);
      @(negedge clk);
      start[d] = 1'b1;
      wc[d]    = w;
      @(negedge clk);
      start[d] = 1'b0;
      for (int j = 0; j < beats; j++) begin
         for (int k = 0; k < nb; k++) data[d][8*k +: 8] = s[j*nb + k];
         dv[d] = 1'b1;
         @(negedge clk);
      end
      dv[d] = 1'b0;
   endtask
   logic [7:0]  p33 [$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
   logic [7:0]  p34 [$] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4,
                            8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF,
                            8'hFF, 8'h00, 8'h00, 8'h01, 8'hF0, 8'h00};
   logic [7:0]  p35 [$];
   logic [7:0]  p36 [$] = '{8'hFF, 8'hFF};
   logic [15:0] r35;
   int          v0;
   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; start[d] = 1'b0; wc[d] = 16'h0; data[d] = 64'h0; dv[d] = 1'b0;
      end
      repeat (2) @(negedge clk);
      check("rst_busy", 16'(busy[1]), 16'd0);
      check("rst_valid", 16'(cv[1]), 16'd0);
      check("rst_error", 16'(err[1]), 16'd0);
      check("rst_calc", calc[1], 16'h0000);
      check("rst_recv", recv[1], 16'h0000);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      run_pkt(0, 1, 16'd9, p33, 1'b0, 1'b0);
      check("nb1_calc", calc[0], 16'h6F91);
      check("nb1_recv", recv[0], 16'h6F91);
      check("nb1_error", 16'(err[0]), 16'd0);
      run_pkt(1, 4, 16'd24, p34, 1'b0, 1'b0);
      check("nb4_calc", calc[1], 16'h00F0);
      check("nb4_recv", recv[1], 16'h00F0);
      check("nb4_error", 16'(err[1]), 16'd0);
      p35 = '{8'h31, 8'h32, 8'h33};
      r35 = crc_ref(p35, 3);
      p35.push_back(r35[7:0]);
      p35.push_back(r35[15:8]);
      run_pkt(1, 4, 16'd3, p35, 1'b0, 1'b1);
      check("split_recv", recv[1], r35);
      check("split_calc", calc[1], r35);
      check("split_error", 16'(err[1]), 16'd0);
      p35[1] = 8'h42;
      run_pkt(1, 4, 16'd3, p35, 1'b0, 1'b0);
      check("bad_recv", recv[1], r35);
      check("bad_calc", calc[1], crc_ref(p35, 3));
      check("bad_error", 16'(err[1]), 16'd1);
      run_pkt(2, 8, 16'd0, p36, 1'b0, 1'b0);
      check("nb8_calc", calc[2], 16'hFFFF);
      check("nb8_recv", recv[2], 16'hFFFF);
      check("nb8_error", 16'(err[2]), 16'd0);
      repeat (3) @(negedge clk);
      check("nb8_hold", calc[2], 16'hFFFF);
      run_pkt(1, 4, 16'd24, p34, 1'b1, 1'b0);
      check("gap_calc", calc[1], 16'h00F0);
      check("gap_error", 16'(err[1]), 16'd0);
      v0 = vcnt[1];
      partial(1, 4, 16'd24, p34, 3);
      check("abort_busy", 16'(busy[1]), 16'd1);
      run_pkt(1, 4, 16'd24, p34, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check("abort_calc", calc[1], 16'h00F0);
      check("abort_pulses", 16'(vcnt[1] - v0), 16'd1);
      v0 = vcnt[1];
      partial(1, 4, 16'd24, p34, 2);
      rst[1]   = 1'b1;
      start[1] = 1'b1;
      wc[1]    = 16'd5;
      @(negedge clk);
      rst[1]   = 1'b0;
      start[1] = 1'b0;
      check("mid_rst_busy", 16'(busy[1]), 16'd0);
      check("mid_rst_calc", calc[1], 16'h0000);
      check("mid_rst_recv", recv[1], 16'h0000);
      data[1] = {8{8'hFF}};
      dv[1]   = 1'b1;
      repeat (4) @(negedge clk);
      dv[1] = 1'b0;
      check("mid_rst_pulses", 16'(vcnt[1] - v0), 16'd0);
      check("mid_rst_idle", 16'(busy[1]), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
